interrupt_controller: RTL and testbench

- Sequences interrupt entry and exit for the MultiCycleProccessor control FSM.
- Arbitrates the external NMI and INT lines, with NMI above INT; INT can be masked by INTD and by an internal enable flag.
- Requests a control-flow diversion at an instruction boundary, captures the EPC and supplies the handler vector.
- Drives the INA acknowledge back to the interrupting device and restores state on eret.

---
 rtl/irq_pkg.sv | 21 ++
 rtl/interrupt_controller_if.sv | 28 ++
 rtl/irq_edge_detect.sv | 23 ++
 rtl/interrupt_controller.sv | 148 ++++++++++++++
 tb/tb_interrupt_controller.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared encodings and default constants for the interrupt controller.
package irq_pkg;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_INT  = 2'b01,
      CAUSE_NMI  = 2'b10
   } irq_cause_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_ACK,
      ST_SERVICE
   } irq_state_e;

   localparam logic [31:0] DEF_NMI_VECTOR = 32'h0000_0180;
   localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0200;
   localparam int          DEF_INA_CYCLES = 2;

endpackage

// File: rtl/interrupt_controller_if.sv
// Control-FSM side of the interrupt controller: diversion handshake, EPC/vector and ie control.
interface interrupt_controller_if #(
   parameter int ADDR_W = 32
) ();

   logic              irq_req;
   logic              irq_ack;
   logic [ADDR_W-1:0] pc_in;
   logic [ADDR_W-1:0] vector;
   logic [1:0]        cause;
   logic [ADDR_W-1:0] epc;
   logic              ei;
   logic              di;
   logic              eret;
   logic              ie;
   logic              nmi_active;

   modport master (
      output irq_ack, pc_in, ei, di, eret,
      input  irq_req, vector, cause, epc, ie, nmi_active
   );

   modport slave (
      input  irq_ack, pc_in, ei, di, eret,
      output irq_req, vector, cause, epc, ie, nmi_active
   );

endinterface

// File: rtl/irq_edge_detect.sv
// NMI rising-edge detector with a sticky pending flag cleared when the NMI is accepted.
module irq_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic nmi,
   input  logic clr,
   output logic pending
);

   logic nmi_q;

   // A fresh edge in the same cycle as the accept re-arms the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         nmi_q   <= 1'b0;
         pending <= 1'b0;
      end else begin
         nmi_q   <= nmi;
         pending <= (nmi & ~nmi_q) | (pending & ~clr);
      end
   end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry/exit sequencer: NMI/INT arbitration, EPC capture, handler vector and INA pulse.
//  state      | meaning
//  ST_IDLE    | no interrupt in flight, waiting for pending NMI or enabled INT
//  ST_REQ     | irq_req high, waiting for irq_ack at an instruction boundary
//  ST_ACK     | INT taken, INA held high for INA_CYCLES cycles
//  ST_SERVICE | handler running, waiting for eret
module interrupt_controller
   import irq_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] NMI_VECTOR = ADDR_W'(DEF_NMI_VECTOR),
   parameter logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(DEF_INT_VECTOR),
   parameter int                INA_CYCLES = DEF_INA_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   INT,
   input  logic                   NMI,
   input  logic                   INTD,
   output logic                   INA,
   interrupt_controller_if.slave  cpu
);

   localparam logic [3:0] INA_LOAD = 4'(INA_CYCLES - 1);

   irq_state_e        state_q, state_d;
   irq_cause_e        cause_q, win_cause, cause_o;
   logic [ADDR_W-1:0] vector_q, win_vec, vector_o;
   logic [ADDR_W-1:0] epc_q;
   logic [3:0]        ina_cnt_q;
   logic              ie_q, saved_ie_q, nmi_active_q;
   logic              nmi_pending, int_eff;
   logic              take, nmi_clr, restore, irq_req, ina;

   irq_edge_detect u_edge (
      .clk     (clk),
      .rst     (rst),
      .nmi     (NMI),
      .clr     (nmi_clr),
      .pending (nmi_pending)
   );

   assign int_eff = INT & ~INTD & ie_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      irq_req   = 1'b0;
      ina       = 1'b0;
      take      = 1'b0;
      nmi_clr   = 1'b0;
      restore   = 1'b0;
      win_cause = CAUSE_NONE;
      win_vec   = vector_q;
      cause_o   = cause_q;
      vector_o  = vector_q;
      if (nmi_pending) begin
         win_cause = CAUSE_NMI;
         win_vec   = NMI_VECTOR;
      end else if (int_eff) begin
         win_cause = CAUSE_INT;
         win_vec   = INT_VECTOR;
      end
      case (state_q)
         ST_IDLE: begin
            if (nmi_pending | int_eff) state_d = ST_REQ;
         end
         ST_REQ: begin
            irq_req  = 1'b1;
            cause_o  = win_cause;
            vector_o = win_vec;
            if (win_cause == CAUSE_NONE) begin
               state_d = ST_IDLE;
            end else if (cpu.irq_ack) begin
               take = 1'b1;
               if (win_cause == CAUSE_NMI) begin
                  nmi_clr = 1'b1;
                  state_d = ST_SERVICE;
               end else begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            ina = 1'b1;
            if (ina_cnt_q == 4'd0) state_d = ST_SERVICE;
         end
         ST_SERVICE: begin
            if (cpu.eret) begin
               restore = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture on accept, restore on eret; ei/di only when no entry sequence is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         cause_q      <= CAUSE_NONE;
         vector_q     <= '0;
         epc_q        <= '0;
         ina_cnt_q    <= 4'd0;
         ie_q         <= 1'b0;
         saved_ie_q   <= 1'b0;
         nmi_active_q <= 1'b0;
      end else begin
         if (take) begin
            cause_q    <= win_cause;
            vector_q   <= win_vec;
            epc_q      <= cpu.pc_in;
            saved_ie_q <= ie_q;
            if (win_cause == CAUSE_NMI) nmi_active_q <= 1'b1;
            else                        ina_cnt_q    <= INA_LOAD;
         end else if (state_q == ST_ACK && ina_cnt_q != 4'd0) begin
            ina_cnt_q <= ina_cnt_q - 4'd1;
         end

         if (restore) begin
            cause_q      <= CAUSE_NONE;
            nmi_active_q <= 1'b0;
         end

         if (take) begin
            ie_q <= 1'b0;
         end else if (restore) begin
            ie_q <= saved_ie_q;
         end else if (state_q == ST_IDLE || state_q == ST_SERVICE) begin
            if (cpu.di)      ie_q <= 1'b0;
            else if (cpu.ei) ie_q <= 1'b1;
         end
      end
   end

   assign INA            = ina;
   assign cpu.irq_req    = irq_req;
   assign cpu.cause      = cause_o;
   assign cpu.vector     = vector_o;
   assign cpu.epc        = epc_q;
   assign cpu.ie         = ie_q;
   assign cpu.nmi_active = nmi_active_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed plan plus randomized traffic against a cycle-level behavioural model of the controller.
module tb_interrupt_controller;

   localparam int          AW    = 32;
   localparam logic [31:0] NMI_V = 32'h0000_0180;
   localparam logic [31:0] INT_V = 32'h0000_0200;
   localparam int          NINA  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic INT = 1'b0, NMI = 1'b0, INTD = 1'b0;
   logic INA;

   interrupt_controller_if #(.ADDR_W(AW)) bus ();

   interrupt_controller #(
      .ADDR_W(AW), .NMI_VECTOR(NMI_V), .INT_VECTOR(INT_V), .INA_CYCLES(NINA)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .INT  (INT),
      .NMI  (NMI),
      .INTD (INTD),
      .INA  (INA),
      .cpu  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: request outstanding, INA cycles left, handler running
   bit          m_req, m_handler, m_pend, m_nmi_prev, m_ie, m_saved, m_active;
   int          m_ina_left, m_cause;
   logic [31:0] m_vec, m_epc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_req = 0; m_handler = 0; m_pend = 0; m_nmi_prev = 0; m_ie = 0;
      m_saved = 0; m_active = 0; m_ina_left = 0; m_cause = 0;
      m_vec = '0; m_epc = '0;
   endtask

   function automatic int winner();
      if (m_pend) return 2;
      if (INT && !INTD && m_ie) return 1;
      return 0;
   endfunction

   task automatic apply_ei_di();
      if (bus.di)      m_ie = 0;
      else if (bus.ei) m_ie = 1;
   endtask

   task automatic model_step();
      int  win;
      bit  edge_b, clr;
      if (rst) begin
         model_reset();
         return;
      end
      win    = winner();
      edge_b = NMI && !m_nmi_prev;
      clr    = 0;
      if (m_req) begin
         if (win == 0) begin
            m_req = 0;
         end else if (bus.irq_ack) begin
            m_epc   = bus.pc_in;
            m_saved = m_ie;
            m_ie    = 0;
            m_cause = win;
            m_vec   = (win == 2) ? NMI_V : INT_V;
            m_req   = 0;
            if (win == 2) begin
               clr = 1; m_active = 1; m_handler = 1;
            end else begin
               m_ina_left = NINA;
            end
         end
      end else if (m_ina_left > 0) begin
         m_ina_left--;
         if (m_ina_left == 0) m_handler = 1;
      end else if (m_handler) begin
         if (bus.eret) begin
            m_ie = m_saved; m_active = 0; m_cause = 0; m_handler = 0;
         end else begin
            apply_ei_di();
         end
      end else begin
         if (m_pend || win != 0) m_req = 1;
         apply_ei_di();
      end
      m_pend     = edge_b || (m_pend && !clr);
      m_nmi_prev = NMI;
   endtask

   task automatic check_all();
      int          win;
      int          e_cause;
      logic [31:0] e_vec;
      win     = winner();
      e_cause = m_req ? win : m_cause;
      e_vec   = (m_req && win == 2) ? NMI_V : (m_req && win == 1) ? INT_V : m_vec;
      chk("ina",        64'(INA),            64'(m_ina_left > 0));
      chk("irq_req",    64'(bus.irq_req),    64'(m_req));
      chk("cause",      64'(bus.cause),      64'(e_cause));
      chk("vector",     64'(bus.vector),     64'(e_vec));
      chk("epc",        64'(bus.epc),        64'(m_epc));
      chk("ie",         64'(bus.ie),         64'(m_ie));
      chk("nmi_active", 64'(bus.nmi_active), 64'(m_active));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic pulse_clear();
      bus.irq_ack = 0; bus.ei = 0; bus.di = 0; bus.eret = 0;
   endtask

   logic [31:0] epc_before;

   initial begin
      model_reset();
      bus.irq_ack = 0; bus.pc_in = '0; bus.ei = 0; bus.di = 0; bus.eret = 0;

      // reset
      rst = 1; step(); step();
      chk("rst_ie", 64'(bus.ie), 64'd0);
      chk("rst_cause", 64'(bus.cause), 64'd0);
      chk("rst_vector", 64'(bus.vector), 64'd0);
      rst = 0; step();

      // INT path with INA pulse
      bus.ei = 1; step(); pulse_clear();
      INT = 1; step();
      chk("int_req_lat", 64'(bus.irq_req), 64'd1);
      bus.irq_ack = 1; bus.pc_in = 32'h40; step(); pulse_clear();
      chk("int_epc", 64'(bus.epc), 64'h40);
      chk("int_cause", 64'(bus.cause), 64'd1);
      chk("int_vector", 64'(bus.vector), 64'h200);
      chk("int_ie", 64'(bus.ie), 64'd0);
      chk("ina_c1", 64'(INA), 64'd1);
      step(); chk("ina_c2", 64'(INA), 64'd1);
      step(); chk("ina_off", 64'(INA), 64'd0);
      INT = 0; bus.eret = 1; step(); pulse_clear();
      chk("eret_ie", 64'(bus.ie), 64'd1);

      // NMI with ie=0
      bus.di = 1; step(); pulse_clear();
      NMI = 1; step(); step();
      chk("nmi_req", 64'(bus.irq_req), 64'd1);
      chk("nmi_cause", 64'(bus.cause), 64'd2);
      chk("nmi_vector", 64'(bus.vector), 64'h180);
      bus.irq_ack = 1; bus.pc_in = 32'h88; step(); pulse_clear();
      chk("nmi_no_ina", 64'(INA), 64'd0);
      chk("nmi_active", 64'(bus.nmi_active), 64'd1);
      NMI = 0; step();
      bus.eret = 1; step(); pulse_clear();
      chk("nmi_eret_ie", 64'(bus.ie), 64'd0);
      chk("nmi_eret_cause", 64'(bus.cause), 64'd0);

      // INT and NMI edge together: NMI first, then INT
      bus.ei = 1; step(); pulse_clear();
      INT = 1; NMI = 1; step();
      chk("both_cause", 64'(bus.cause), 64'd2);
      bus.irq_ack = 1; step(); pulse_clear();
      chk("both_no_ina", 64'(INA), 64'd0);
      bus.eret = 1; step(); pulse_clear();
      chk("both_ie_back", 64'(bus.ie), 64'd1);
      step();
      chk("both_int_cause", 64'(bus.cause), 64'd1);
      bus.irq_ack = 1; step(); pulse_clear();
      chk("both_int_ina", 64'(INA), 64'd1);
      step(); step();
      INT = 0; NMI = 0; bus.eret = 1; step(); pulse_clear();

      // INTD masking
      INTD = 1; INT = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("intd_req", 64'(bus.irq_req), 64'd0);
         chk("intd_ina", 64'(INA), 64'd0);
      end
      INTD = 0; step();
      chk("intd_drop_req", 64'(bus.irq_req), 64'd1);

      // withdrawal in REQ, then ei+di together
      epc_before = bus.epc;
      INT = 0; step();
      chk("wd_req", 64'(bus.irq_req), 64'd0);
      chk("wd_epc", 64'(bus.epc), 64'(epc_before));
      bus.ei = 1; bus.di = 1; step(); pulse_clear();
      chk("eidi_ie", 64'(bus.ie), 64'd0);

      // reset in the first ACK cycle
      bus.ei = 1; step(); pulse_clear();
      INT = 1; step();
      bus.irq_ack = 1; step(); pulse_clear();
      chk("ack_ina", 64'(INA), 64'd1);
      rst = 1; step();
      chk("mid_rst_ina", 64'(INA), 64'd0);
      chk("mid_rst_ie", 64'(bus.ie), 64'd0);
      chk("mid_rst_req", 64'(bus.irq_req), 64'd0);
      rst = 0; INT = 0; step(); step();
      chk("mid_rst_nopend", 64'(bus.irq_req), 64'd0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 9) == 0)  INT  = ~INT;
         if ($urandom_range(0, 7) == 0)  NMI  = ~NMI;
         if ($urandom_range(0, 15) == 0) INTD = ~INTD;
         bus.irq_ack = ($urandom_range(0, 2) == 0);
         bus.ei      = ($urandom_range(0, 5) == 0);
         bus.di      = ($urandom_range(0, 7) == 0);
         bus.eret    = ($urandom_range(0, 4) == 0);
         bus.pc_in   = $urandom;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
